// File: rtl/spi_fsm.sv
// spi_fsm: SPI memory transaction sequencer. It counts header and data bits
// and drives the address-latch, shift-register load, memory write and MISO
// enables.
// Define SPI_FSM_ERR_EN to add the protoErr output. protoErr pulses for one
// cycle when cs rises in the middle of a frame.
module spi_fsm #(
  parameter int WIDTH = 8,
  parameter int MEM_LATENCY = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic cs,
  input  logic sclkPosEdge,
  input  logic sclkNegEdge,
  input  logic rwBit,
  output logic addrWE,
  output logic srWE,
  output logic dmWE,
  output logic misoBufE
`ifdef SPI_FSM_ERR_EN
  ,
  output logic protoErr
`endif
);
  localparam int CNT_MAX = WIDTH > 7 ? WIDTH : 7;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] LAT_LAST = CW'(MEM_LATENCY > 0 ? MEM_LATENCY - 1 : 0);

  typedef enum logic [3:0] {
    IDLE, GET_ADDR, GOT_ADDR, READ_WAIT, READ_LOAD,
    READ_SEND, WRITE_GET, WRITE_STORE, DONE
  } state_t;

  state_t state, stateNext;
  logic [CW-1:0] cnt, cntNext;

  // state and bit counter register; reset wins over everything
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= stateNext;
      cnt <= cntNext;
    end
  end

  // next-state and counter logic; cs high aborts any active frame first
  always_comb begin
    stateNext = state;
    cntNext = cnt;
    if (state != IDLE && cs) begin
      stateNext = IDLE;
      cntNext = '0;
    end else begin
      case (state)
        IDLE: begin
          cntNext = '0;
          stateNext = cs ? IDLE : GET_ADDR;
        end
        GET_ADDR:
          if (sclkPosEdge) begin
            stateNext = cnt == BIT_LAST ? GOT_ADDR : GET_ADDR;
            cntNext = cnt == BIT_LAST ? '0 : cnt + 1'b1;
          end
        GOT_ADDR: begin
          cntNext = '0;
          stateNext = rwBit ? (MEM_LATENCY > 0 ? READ_WAIT : READ_LOAD) : WRITE_GET;
        end
        READ_WAIT: begin
          stateNext = cnt == LAT_LAST ? READ_LOAD : READ_WAIT;
          cntNext = cnt == LAT_LAST ? '0 : cnt + 1'b1;
        end
        READ_LOAD: begin
          cntNext = '0;
          stateNext = READ_SEND;
        end
        READ_SEND:
          if (sclkNegEdge) begin
            stateNext = cnt == BIT_LAST ? DONE : READ_SEND;
            cntNext = cnt == BIT_LAST ? '0 : cnt + 1'b1;
          end
        WRITE_GET:
          if (sclkPosEdge) begin
            stateNext = cnt == BIT_LAST ? WRITE_STORE : WRITE_GET;
            cntNext = cnt == BIT_LAST ? '0 : cnt + 1'b1;
          end
        WRITE_STORE: stateNext = DONE;
        DONE: stateNext = DONE;
        default: begin
          stateNext = IDLE;
          cntNext = '0;
        end
      endcase
    end
  end

  assign addrWE = state == GOT_ADDR;
  assign srWE = state == READ_LOAD;
  assign dmWE = state == WRITE_STORE;
  assign misoBufE = state == READ_SEND;

`ifdef SPI_FSM_ERR_EN
  // one-cycle pulse when a frame is cut short by cs rising
  always_ff @(posedge clk) protoErr <= !reset && cs && state != IDLE && state != DONE;
`endif
endmodule
